// File: rtl/acc_pkg.sv
// Shared constants for the accumulate/requantize block: FSM state encoding,
// beat-counter width and a saturating counter increment.
// No ports; imported by acc_requant and requant_sat.
package acc_pkg;

  localparam int CNT_WIDTH = 16;

  // Two-state FSM, kept as plain constants for legacy-tool compatibility.
  localparam logic [0:0] ST_ACC = 1'b0;  // accepting beats
  localparam logic [0:0] ST_OUT = 1'b1;  // presenting a result

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizer: optional round-half-up, arithmetic right shift by SHIFT, then clamp to OUT_WIDTH.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: acc (ACC_WIDTH signed in), q (OUT_WIDTH signed out). Macro ACC_REQUANT_ROUND_EN enables rounding.
module requant_sat
  import acc_pkg::*;
#(
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] q
);

  // One guard bit so the rounding add can never wrap.
  localparam int EW = ACC_WIDTH + 1;

  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`ifdef ACC_REQUANT_ROUND_EN
  localparam logic signed [EW-1:0] RND = {{(EW-1){1'b0}}, 1'b1} << (SHIFT-1);
`endif

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shifted;

  always_comb begin
    ext = {acc[ACC_WIDTH-1], acc};
`ifdef ACC_REQUANT_ROUND_EN
    ext = ext + RND;
`endif
    shifted = ext >>> SHIFT;
    if (shifted > MAX_V) begin
      q = MAX_V[OUT_WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      q = MIN_V[OUT_WIDTH-1:0];
    end else begin
      q = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/acc_requant.sv
// Accumulates signed beats until d_last_i, then presents a shifted, saturated result with beat count and wrap flag.
// Latency: result valid one cycle after the accepting edge of the last beat.
// Backpressure: while a result waits for d_ready_i, d_ready_o is low and inputs are ignored.
// Ports: clk, rst (sync active-low); d_i/d_valid_i/d_last_i/d_ready_o in; d_o/d_valid_o/d_ready_i/cnt_o/ovf_o out.
// Macro ACC_REQUANT_ROUND_EN selects round-half-up instead of truncation in requant_sat.
module acc_requant
  import acc_pkg::*;
#(
  parameter int IN_WIDTH  = 33,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  d_i,
  input  logic                        d_valid_i,
  input  logic                        d_last_i,
  output logic                        d_ready_o,
  output logic signed [OUT_WIDTH-1:0] d_o,
  output logic                        d_valid_o,
  input  logic                        d_ready_i,
  output logic [CNT_WIDTH-1:0]        cnt_o,
  output logic                        ovf_o
);

  logic [0:0]                  state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] d_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        ovf;
  logic                        sum_ovf;
  logic signed [OUT_WIDTH-1:0] q;

  assign d_ready_o = (state == ST_ACC);
  assign d_valid_o = (state == ST_OUT);
  assign cnt_o     = cnt;
  assign ovf_o     = ovf;

  assign d_ext = {{(ACC_WIDTH-IN_WIDTH){d_i[IN_WIDTH-1]}}, d_i};
  assign sum   = acc + d_ext;  // wraps modulo 2^ACC_WIDTH

  // Two same-signed operands producing an opposite-signed sum means the add wrapped.
  assign sum_ovf = (acc[ACC_WIDTH-1] == d_ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

  // Requantize the sum that includes the current beat, so the last beat is counted.
  requant_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_requant_sat (
    .acc (sum),
    .q   (q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      d_o   <= '0;
    end else if (state == ST_ACC) begin
      if (d_valid_i) begin
        acc <= sum;
        cnt <= sat_inc(cnt);
        ovf <= ovf | sum_ovf;
        if (d_last_i) begin
          state <= ST_OUT;
          d_o   <= q;
        end
      end
    end else begin
      // d_o keeps its last value after the handshake; only the sum state clears.
      if (d_ready_i) begin
        state <= ST_ACC;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acc_requant.sv
// Scoreboard bench for acc_requant (IN 33, OUT 16, SHIFT 4) with a 48-bit and a 34-bit accumulator instance.
// Both instances share stimulus; expected results are queued by the driver and popped by the monitor.
module tb_acc_requant;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [32:0] d_i;
  logic               d_valid_i;
  logic               d_last_i;
  logic               d_ready_i;

  logic               d_ready_o,  d_valid_o,  ovf_o;
  logic signed [15:0] d_o;
  logic [15:0]        cnt_o;
  logic               d_ready_o34, d_valid_o34, ovf_o34;
  logic signed [15:0] d_o34;
  logic [15:0]        cnt_o34;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic signed [15:0] d;
    logic [15:0]        cnt;
    logic               ovf;
    logic signed [15:0] d34;
    logic               ovf34;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  acc_requant #(.IN_WIDTH(33), .ACC_WIDTH(48), .OUT_WIDTH(16), .SHIFT(4)) u_dut (
    .clk(clk), .rst(rst), .d_i(d_i), .d_valid_i(d_valid_i), .d_last_i(d_last_i),
    .d_ready_o(d_ready_o), .d_o(d_o), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
    .cnt_o(cnt_o), .ovf_o(ovf_o)
  );

  acc_requant #(.IN_WIDTH(33), .ACC_WIDTH(34), .OUT_WIDTH(16), .SHIFT(4)) u_dut34 (
    .clk(clk), .rst(rst), .d_i(d_i), .d_valid_i(d_valid_i), .d_last_i(d_last_i),
    .d_ready_o(d_ready_o34), .d_o(d_o34), .d_valid_o(d_valid_o34), .d_ready_i(d_ready_i),
    .cnt_o(cnt_o34), .ovf_o(ovf_o34)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_result(input int d, input int cnt, input bit ovf, input int d34, input bit ovf34);
    exp_t e;
    e.d = 16'(d); e.cnt = 16'(cnt); e.ovf = ovf; e.d34 = 16'(d34); e.ovf34 = ovf34;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the DUT to accept, then issues one beat on the next edge.
  task automatic beat(input logic signed [32:0] v, input bit last);
    int w = 0;
    while (!d_ready_o && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!d_ready_o) check("ready_timeout", d_ready_o, 1);
    d_i = v; d_valid_i = 1'b1; d_last_i = last;
    @(posedge clk); #1;
    d_valid_i = 1'b0; d_last_i = 1'b0;
    if (last) check("latency_valid", d_valid_o, 1);
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || !d_ready_o) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: compare on every output handshake, then confirm valid drops.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (d_valid_o && d_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_output", d_o, 0);
          check("unexpected_output_valid", d_valid_o, 0);
        end else begin
          e = sb.pop_front();
          check("d_o", d_o, e.d);
          check("cnt_o", cnt_o, e.cnt);
          check("ovf_o", ovf_o, e.ovf);
          check("d_o_acc34", d_o34, e.d34);
          check("ovf_o_acc34", ovf_o34, e.ovf34);
          check("valid_lockstep_acc34", d_valid_o34, 1);
        end
        @(negedge clk);
        check("valid_one_cycle", d_valid_o, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; d_i = '0; d_valid_i = 1'b0; d_last_i = 1'b0; d_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d_o", d_o, 0);
    check("rst_valid", d_valid_o, 0);
    check("rst_cnt", cnt_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_ready", d_ready_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // 16+32+48 = 96, 96>>4 = 6 (rounded: 104>>4 = 6)
    expect_result(6, 3, 0, 6, 0);
    beat(33'sd16, 0);
    beat(33'sd32, 0);
    check("running_cnt", cnt_o, 2);
    beat(33'sd48, 1);
    drain();

`ifdef ACC_REQUANT_ROUND_EN
    expect_result(2, 1, 0, 2, 0);      // (24+8)>>4
    beat(33'sd24, 1);
    expect_result(-1, 1, 0, -1, 0);    // (-24+8)>>4 = -1
    beat(-33'sd24, 1);
`else
    expect_result(1, 1, 0, 1, 0);      // 24>>4 = 1.5 floored
    beat(33'sd24, 1);
    expect_result(-2, 1, 0, -2, 0);    // -24>>4 = -1.5 floored
    beat(-33'sd24, 1);
`endif
    drain();

    // 2^24>>4 = 2^20, clamps to the 16-bit extremes
    expect_result(32767, 1, 0, 32767, 0);
    beat(33'sd16777216, 1);
    expect_result(-32768, 1, 0, -32768, 0);
    beat(-33'sd16777216, 1);
    drain();

    // Stall: result held for 5 cycles while a valid beat is offered and ignored.
    d_ready_i = 1'b0;
    expect_result(1, 1, 0, 1, 0);      // 16>>4 = 1 (rounded 24>>4 = 1)
    beat(33'sd16, 1);
    d_i = 33'sd1000; d_valid_i = 1'b1; d_last_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_d_o", d_o, 1);
      check("stall_ready", d_ready_o, 0);
      check("stall_cnt", cnt_o, 1);
    end
    d_valid_i = 1'b0; d_last_i = 1'b0;
    d_ready_i = 1'b1;
    drain();
    expect_result(2, 1, 0, 2, 0);      // sums from zero: 32>>4 = 2
    beat(33'sd32, 1);
    drain();

    // Reset while a result is pending: it must never appear.
    d_ready_i = 1'b0;
    beat(33'sd48, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_out_valid", d_valid_o, 0);
    check("rst_out_ready", d_ready_o, 1);
    check("rst_out_d_o", d_o, 0);
    d_ready_i = 1'b1;

    // Reset mid-accumulation discards the partial 200.
    beat(33'sd100, 0);
    beat(33'sd100, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_mid_cnt", cnt_o, 0);
    expect_result(6, 1, 0, 6, 0);      // 100>>4 = 6 (rounded 108>>4 = 6)
    beat(33'sd100, 1);
    drain();

    // Overflow on the 34-bit instance: two beats of 2^32-1 give 2^33-2, which
    // still fits in 34 bits, so a third beat is needed to wrap. 3*(2^32-1)
    // wraps to -4294967299 -> clamps to -32768; the 48-bit copy clamps to 32767.
    expect_result(32767, 3, 0, -32768, 1);
    beat(33'sd4294967295, 0);
    beat(33'sd4294967295, 0);
    check("acc34_no_ovf_yet", ovf_o34, 0);
    beat(33'sd4294967295, 1);
    drain();
    check("acc34_ovf_cleared", ovf_o34, 0);
    check("acc34_cnt_cleared", cnt_o34, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
